// File: rtl/mopshub_clk_pkg.sv
// Shared types and constants for the forwarded-clock enable sequencer.
package mopshub_clk_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WAIT_LOCK,
        ST_SETTLE,
        ST_RUN,
        ST_STOP,
        ST_HOLDOFF
    } state_t;

    localparam int LOSS_CNT_W = 8;
    localparam logic [LOSS_CNT_W-1:0] LOSS_CNT_MAX = '1;

    // One counter serves all three timed phases, so it is sized for the longest.
    function automatic int cnt_width(input int a, input int b, input int c);
        int m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        return $clog2(m) + 1;
    endfunction

endpackage

// File: rtl/clk_fwd_enable_ctrl_if.sv
// Control/status bundle between the CSR bank, the MMCM lock and the output DDR register.
interface clk_fwd_enable_ctrl_if;

    logic                                  locked;
    logic                                  en_req;
    logic                                  lock_lost_clr;
    logic                                  oddr_ce;
    logic                                  oddr_rst;
    logic                                  fwd_active;
    logic                                  lock_lost;
    logic [mopshub_clk_pkg::LOSS_CNT_W-1:0] loss_cnt;

    modport slave (
        input  locked, en_req, lock_lost_clr,
        output oddr_ce, oddr_rst, fwd_active, lock_lost, loss_cnt
    );

    modport master (
        output locked, en_req, lock_lost_clr,
        input  oddr_ce, oddr_rst, fwd_active, lock_lost, loss_cnt
    );

endinterface

// File: rtl/sync_2ff.sv
// Generic two-flop bit synchronizer, resets to 0.
module sync_2ff (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic meta_q;
    logic sync_q;

    // Two back-to-back flops give the first stage a full cycle to resolve.
    always_ff @(posedge clk) begin
        if (rst) begin
            meta_q <= 1'b0;
            sync_q <= 1'b0;
        end else begin
            meta_q <= d;
            sync_q <= meta_q;
        end
    end

    assign q = sync_q;

endmodule

// File: rtl/clk_fwd_enable_ctrl.sv
// Forwarded-clock enable sequencer: gates the output DDR register on MMCM lock
// and parks the forwarded clock low on stop or lock loss.
//
//   state      | meaning
//   -----------+-----------------------------------------------------------
//   IDLE       | output parked low, waiting for en_req
//   WAIT_LOCK  | requested, waiting for synchronized lock
//   SETTLE     | lock seen, counting SETTLE_CYCLES of stable lock
//   RUN        | clock forwarded (ce=1, ddr reset released)
//   STOP       | ddr reset asserted with ce still high so Q is forced low
//   HOLDOFF    | quiet time after a lock loss, en_req ignored
module clk_fwd_enable_ctrl
    import mopshub_clk_pkg::*;
#(
    parameter int SETTLE_CYCLES  = 1024,
    parameter int STOP_CYCLES    = 2,
    parameter int HOLDOFF_CYCLES = 256
) (
    input  logic                  clk,
    input  logic                  rst,
    clk_fwd_enable_ctrl_if.slave  ctl
);

    localparam int CNT_W = cnt_width(SETTLE_CYCLES, STOP_CYCLES, HOLDOFF_CYCLES);
    localparam logic [CNT_W-1:0] SETTLE_LAST  = CNT_W'(SETTLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] STOP_LAST    = CNT_W'(STOP_CYCLES - 1);
    localparam logic [CNT_W-1:0] HOLDOFF_LAST = CNT_W'(HOLDOFF_CYCLES - 1);

    logic                  locked_s;
    state_t                state_q, state_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic                  fault_q, fault_d;
    logic                  loss_event;
    logic                  ce_q, orst_q, fwd_q;
    logic                  lock_lost_q;
    logic [LOSS_CNT_W-1:0] loss_cnt_q;

    sync_2ff u_sync_locked (
        .clk (clk),
        .rst (rst),
        .d   (ctl.locked),
        .q   (locked_s)
    );

    // Next-state, shared counter and fault-flag update.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        fault_d    = fault_q;
        loss_event = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (ctl.en_req) state_d = ST_WAIT_LOCK;
            end
            ST_WAIT_LOCK: begin
                if (!ctl.en_req) begin
                    state_d = ST_IDLE;
                end else if (locked_s) begin
                    state_d = ST_SETTLE;
                    cnt_d   = '0;
                end
            end
            ST_SETTLE: begin
                if (!ctl.en_req) begin
                    state_d = ST_IDLE;
                end else if (!locked_s) begin
                    state_d = ST_WAIT_LOCK;
                end else if (cnt_q == SETTLE_LAST) begin
                    state_d = ST_RUN;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ST_RUN: begin
                // Lock loss takes priority so a simultaneous stop is still logged.
                if (!locked_s) begin
                    state_d    = ST_STOP;
                    fault_d    = 1'b1;
                    loss_event = 1'b1;
                    cnt_d      = STOP_LAST;
                end else if (!ctl.en_req) begin
                    state_d = ST_STOP;
                    fault_d = 1'b0;
                    cnt_d   = STOP_LAST;
                end
            end
            ST_STOP: begin
                if (cnt_q == '0) begin
                    fault_d = 1'b0;
                    if (fault_q) begin
                        state_d = ST_HOLDOFF;
                        cnt_d   = HOLDOFF_LAST;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            ST_HOLDOFF: begin
                if (cnt_q == '0) state_d = ST_IDLE;
                else             cnt_d   = cnt_q - CNT_W'(1);
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State, counter, registered Moore outputs and status flags.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            fault_q     <= 1'b0;
            ce_q        <= 1'b0;
            orst_q      <= 1'b1;
            fwd_q       <= 1'b0;
            lock_lost_q <= 1'b0;
            loss_cnt_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            fault_q <= fault_d;
            ce_q    <= (state_d == ST_RUN) || (state_d == ST_STOP);
            orst_q  <= (state_d != ST_RUN);
            fwd_q   <= (state_d == ST_RUN);
            if (loss_event)             lock_lost_q <= 1'b1;
            else if (ctl.lock_lost_clr) lock_lost_q <= 1'b0;
            if (loss_event && (loss_cnt_q != LOSS_CNT_MAX))
                loss_cnt_q <= loss_cnt_q + LOSS_CNT_W'(1);
        end
    end

    assign ctl.oddr_ce    = ce_q;
    assign ctl.oddr_rst   = orst_q;
    assign ctl.fwd_active = fwd_q;
    assign ctl.lock_lost  = lock_lost_q;
    assign ctl.loss_cnt   = loss_cnt_q;

endmodule

// File: tb/tb_clk_fwd_enable_ctrl.sv
// Directed bench for clk_fwd_enable_ctrl with SETTLE=16, STOP=2, HOLDOFF=256.
module tb_clk_fwd_enable_ctrl;

    logic clk = 1'b0;
    logic rst;
    int   errors = 0;
    int   checks = 0;

    clk_fwd_enable_ctrl_if ctl ();

    clk_fwd_enable_ctrl #(
        .SETTLE_CYCLES  (16),
        .STOP_CYCLES    (2),
        .HOLDOFF_CYCLES (256)
    ) dut (
        .clk (clk),
        .rst (rst),
        .ctl (ctl)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_out(input string tag, input logic ce, input logic orst, input logic fwd);
        chk({tag, "_ce"},  32'(ctl.oddr_ce),    32'(ce));
        chk({tag, "_rst"}, 32'(ctl.oddr_rst),   32'(orst));
        chk({tag, "_fwd"}, 32'(ctl.fwd_active), 32'(fwd));
    endtask

    task automatic wait_fwd(input logic val, input int maxc);
        int n = 0;
        while (ctl.fwd_active !== val && n < maxc) begin
            tick();
            n++;
        end
        chk("wait_fwd", 32'(ctl.fwd_active), 32'(val));
    endtask

    initial begin
        rst = 1'b1;
        ctl.locked = 1'b0;
        ctl.en_req = 1'b0;
        ctl.lock_lost_clr = 1'b0;
        repeat (3) tick();
        chk_out("reset", 1'b0, 1'b1, 1'b0);
        chk("reset_lock_lost", 32'(ctl.lock_lost), 32'd0);
        chk("reset_loss_cnt", 32'(ctl.loss_cnt), 32'd0);

        rst = 1'b0;
        ctl.locked = 1'b1;
        repeat (4) tick();
        chk_out("idle_locked", 1'b0, 1'b1, 1'b0);

        // Start latency: WAIT_LOCK, SETTLE, then 16 counted cycles.
        ctl.en_req = 1'b1;
        repeat (17) tick();
        chk_out("start_pre", 1'b0, 1'b1, 1'b0);
        tick();
        chk_out("start_run", 1'b1, 1'b0, 1'b1);

        // Software stop: reset with ce high for 2 cycles, then ce low.
        ctl.en_req = 1'b0;
        tick();
        chk_out("stop_1", 1'b1, 1'b1, 1'b0);
        tick();
        chk_out("stop_2", 1'b1, 1'b1, 1'b0);
        tick();
        chk_out("stop_idle", 1'b0, 1'b1, 1'b0);
        chk("stop_loss_cnt", 32'(ctl.loss_cnt), 32'd0);
        chk("stop_lock_lost", 32'(ctl.lock_lost), 32'd0);

        // Lock glitch at settle count 8 restarts the full settle count.
        ctl.en_req = 1'b1;
        repeat (10) tick();
        ctl.locked = 1'b0;
        repeat (5) tick();
        ctl.locked = 1'b1;
        chk_out("glitch_wait", 1'b0, 1'b1, 1'b0);
        repeat (18) tick();
        chk_out("glitch_pre", 1'b0, 1'b1, 1'b0);
        tick();
        chk_out("glitch_run", 1'b1, 1'b0, 1'b1);
        chk("glitch_lock_lost", 32'(ctl.lock_lost), 32'd0);

        // Lock loss and en_req drop reach the FSM on the same edge: fault wins.
        ctl.locked = 1'b0;
        tick();
        tick();
        ctl.en_req = 1'b0;
        tick();
        ctl.locked = 1'b1;
        chk_out("both_stop", 1'b1, 1'b1, 1'b0);
        chk("both_lock_lost", 32'(ctl.lock_lost), 32'd1);
        chk("both_loss_cnt", 32'(ctl.loss_cnt), 32'd1);
        repeat (2) tick();
        chk_out("both_holdoff", 1'b0, 1'b1, 1'b0);
        repeat (260) tick();
        chk_out("both_no_rearm", 1'b0, 1'b1, 1'b0);
        chk("both_lock_lost_hold", 32'(ctl.lock_lost), 32'd1);
        ctl.lock_lost_clr = 1'b1;
        tick();
        ctl.lock_lost_clr = 1'b0;
        chk("clr_alone_1", 32'(ctl.lock_lost), 32'd0);
        chk("clr_keeps_cnt", 32'(ctl.loss_cnt), 32'd1);

        // Holdoff length: loss with en_req held, relock, exact re-entry to RUN.
        ctl.en_req = 1'b1;
        repeat (18) tick();
        chk_out("rearm_run", 1'b1, 1'b0, 1'b1);
        ctl.locked = 1'b0;
        repeat (3) tick();
        ctl.locked = 1'b1;
        chk("loss2_lock_lost", 32'(ctl.lock_lost), 32'd1);
        chk("loss2_cnt", 32'(ctl.loss_cnt), 32'd2);
        repeat (275) tick();
        chk_out("holdoff_pre", 1'b0, 1'b1, 1'b0);
        tick();
        chk_out("holdoff_run", 1'b1, 1'b0, 1'b1);

        // Repeated lock losses drive loss_cnt into saturation.
        for (int i = 0; i < 255; i++) begin
            wait_fwd(1'b1, 400);
            ctl.locked = 1'b0;
            repeat (3) tick();
            ctl.locked = 1'b1;
        end
        chk("sat_loss_cnt", 32'(ctl.loss_cnt), 32'd255);
        chk("sat_lock_lost", 32'(ctl.lock_lost), 32'd1);
        ctl.lock_lost_clr = 1'b1;
        tick();
        ctl.lock_lost_clr = 1'b0;
        chk("clr_alone_2", 32'(ctl.lock_lost), 32'd0);

        // Clear on the same edge as a new loss: set wins.
        wait_fwd(1'b1, 400);
        ctl.locked = 1'b0;
        tick();
        tick();
        ctl.lock_lost_clr = 1'b1;
        tick();
        ctl.lock_lost_clr = 1'b0;
        ctl.locked = 1'b1;
        chk("set_wins", 32'(ctl.lock_lost), 32'd1);
        chk("sat_hold", 32'(ctl.loss_cnt), 32'd255);
        ctl.lock_lost_clr = 1'b1;
        tick();
        ctl.lock_lost_clr = 1'b0;
        chk("clr_alone_3", 32'(ctl.lock_lost), 32'd0);

        // Reset during STOP.
        wait_fwd(1'b1, 400);
        ctl.en_req = 1'b0;
        tick();
        chk_out("rst_stop_pre", 1'b1, 1'b1, 1'b0);
        rst = 1'b1;
        tick();
        chk_out("rst_stop", 1'b0, 1'b1, 1'b0);
        chk("rst_stop_loss_cnt", 32'(ctl.loss_cnt), 32'd0);
        chk("rst_stop_lock_lost", 32'(ctl.lock_lost), 32'd0);

        // Reset during SETTLE, then a full restart including synchronizer refill.
        rst = 1'b0;
        ctl.en_req = 1'b1;
        repeat (8) tick();
        rst = 1'b1;
        tick();
        chk_out("rst_settle", 1'b0, 1'b1, 1'b0);
        chk("rst_settle_loss_cnt", 32'(ctl.loss_cnt), 32'd0);
        rst = 1'b0;
        repeat (18) tick();
        chk_out("restart_pre", 1'b0, 1'b1, 1'b0);
        tick();
        chk_out("restart_run", 1'b1, 1'b0, 1'b1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
